// File: rtl/oport_arb.sv
// oport_arb: output-port arbiter for a 5-input wormhole router.
// Picks one input per packet in round-robin order, holds the crossbar
// select until that packet's tail flit leaves, and tracks downstream credits
// for each output VC.
//
// Ports:
//   clk, rst_            single clock; asynchronous active-low reset
//   port_k, req_k        input k requests output port port_k (k=0..4)
//   ivch_k               output VC requested by input k
//   ivalid_k, itail_k    input k presents a flit / the flit is a tail
//   credit_in/_vch       one credit returned for VC credit_vch
//   sel                  one-hot crossbar select (registered)
//   grt                  one-hot send permission (sel gated by credit)
//   busy                 output locked to a packet
//   cred_err             sticky credit-overflow flag
module oport_arb #(
  parameter int PORTID   = 0,
  parameter int CRED_MAX = 4,
  parameter int NVC      = 2,
  localparam int VW      = (NVC > 1) ? $clog2(NVC) : 1,
  localparam int CW      = $clog2(CRED_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic [2:0]    port_0,
  input  logic [2:0]    port_1,
  input  logic [2:0]    port_2,
  input  logic [2:0]    port_3,
  input  logic [2:0]    port_4,
  input  logic          req_0,
  input  logic          req_1,
  input  logic          req_2,
  input  logic          req_3,
  input  logic          req_4,
  input  logic [VW-1:0] ivch_0,
  input  logic [VW-1:0] ivch_1,
  input  logic [VW-1:0] ivch_2,
  input  logic [VW-1:0] ivch_3,
  input  logic [VW-1:0] ivch_4,
  input  logic          ivalid_0,
  input  logic          ivalid_1,
  input  logic          ivalid_2,
  input  logic          ivalid_3,
  input  logic          ivalid_4,
  input  logic          itail_0,
  input  logic          itail_1,
  input  logic          itail_2,
  input  logic          itail_3,
  input  logic          itail_4,
  input  logic          credit_in,
  input  logic [VW-1:0] credit_vch,
  output logic [4:0]    sel,
  output logic [4:0]    grt,
  output logic          busy,
  output logic          cred_err
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state, state_nx;
  logic [2:0]      ptr, ptr_nx;
  logic [4:0]      sel_nx;
  logic [VW-1:0]   lvc, lvc_nx;
  logic [CW-1:0]   credit [NVC];

  logic [4:0]      req_v, ivalid_v, itail_v, elig;
  logic [2:0]      port_v [5];
  logic [VW-1:0]   ivch_v [5];
  logic            found, sent, tail_sent;
  logic [2:0]      win, lock_idx;
  logic [NVC-1:0]  inc, dec;

  assign req_v    = {req_4, req_3, req_2, req_1, req_0};
  assign ivalid_v = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
  assign itail_v  = {itail_4, itail_3, itail_2, itail_1, itail_0};
  assign port_v   = '{port_0, port_1, port_2, port_3, port_4};
  assign ivch_v   = '{ivch_0, ivch_1, ivch_2, ivch_3, ivch_4};

  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  function automatic logic [2:0] enc5(input logic [4:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 5; i++)
      if (oh[i]) idx = 3'(i);
    return idx;
  endfunction

  // Eligibility sees the credit registered at the start of the cycle.
  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < 5; k++)
      elig[k] = req_v[k] && (port_v[k] == 3'(PORTID)) && (credit[ivch_v[k]] != '0);
  end

  // Round-robin search starting at ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (!found && elig[wrap5({1'b0, ptr} + 4'(i))]) begin
        found = 1'b1;
        win   = wrap5({1'b0, ptr} + 4'(i));
      end
    end
  end

  assign busy      = (state == LOCK);
  assign grt       = (busy && credit[lvc] != '0) ? sel : '0;
  assign sent      = |(grt & ivalid_v);
  assign tail_sent = |(grt & ivalid_v & itail_v);
  assign lock_idx  = enc5(sel);

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    lvc_nx   = lvc;
    ptr_nx   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = LOCK;
          sel_nx   = 5'(1) << win;
          lvc_nx   = ivch_v[win];
        end
      end
      LOCK: begin
        if (tail_sent) begin
          state_nx = IDLE;
          sel_nx   = '0;
          ptr_nx   = wrap5({1'b0, lock_idx} + 4'd1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      sel   <= '0;
      lvc   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      lvc   <= lvc_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned v = 0; v < NVC; v++) begin
      inc[v] = credit_in && (credit_vch == VW'(v));
      dec[v] = sent && (lvc == VW'(v));
    end
  end

  // Simultaneous return and consumption on one VC cancel out; a return
  // onto a full counter is dropped and flagged.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int unsigned v = 0; v < NVC; v++)
        credit[v] <= CW'(CRED_MAX);
      cred_err <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NVC; v++) begin
        if (dec[v] && !inc[v]) begin
          credit[v] <= credit[v] - CW'(1);
        end else if (inc[v] && !dec[v]) begin
          if (credit[v] == CW'(CRED_MAX))
            cred_err <= 1'b1;
          else
            credit[v] <= credit[v] + CW'(1);
        end
      end
    end
  end

endmodule
